// File: rtl/packet_tx_reader.sv
// Streams buffered packets out as MII-style frames.
// Pops a length, sends preamble/SFD, then L buffer bytes.
module packet_tx_reader #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pDEPTH_RAM         = 3072,
  parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1,
  parameter int pIFG               = 12
) (
  input  logic                          iclk,
  input  logic                          i_rst,
  input  logic                          i_tx_enable,
  input  logic                          i_len_valid,
  input  logic [pLEN_WIDTH-1:0]         i_len,
  output logic                          o_len_rd,
  output logic [$clog2(pDEPTH_RAM)-1:0] o_rd_addr,
  input  logic [pDATA_WIDTH-1:0]        i_rd_data,
  output logic                          o_tx_en,
  output logic [pDATA_WIDTH-1:0]        o_txd,
  output logic                          o_len_err,
  output logic [15:0]                   o_pkt_cnt
);

  localparam int AW = $clog2(pDEPTH_RAM);
  localparam int LW = pLEN_WIDTH;
  localparam int SW = ((AW > LW) ? AW : LW) + 1;

  typedef enum logic [2:0] {
    IDLE, POP, PREAMBLE, SFD, DATA, SKIP, IFG
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_inc, ptr_skip;
  logic [LW-1:0] len_q, cnt;
  logic [15:0]   pkt_cnt;
  logic [SW-1:0] lmod, psum;
  logic          legal, last_data, ptr_step;

  assign legal = (i_len != '0) &&
                 (i_len <= LW'(pMAX_PACKET_LENGHT));
  assign last_data = (state == DATA) &&
                     (cnt == len_q - LW'(1));
  assign ptr_step = (state == SFD) ||
                    ((state == DATA) && !last_data);
  assign ptr_inc = (ptr == AW'(pDEPTH_RAM - 1)) ?
                   '0 : ptr + AW'(1);

  // Skip pointer: start + (L mod depth), wrapped; one subtract
  // per stage suffices since L stays below twice the depth.
  always_comb begin
    lmod = SW'(len_q);
    if (lmod >= SW'(pDEPTH_RAM))
      lmod = lmod - SW'(pDEPTH_RAM);
    psum = SW'(ptr) + lmod;
    if (psum >= SW'(pDEPTH_RAM))
      psum = psum - SW'(pDEPTH_RAM);
    ptr_skip = AW'(psum);
  end

  // State register.
  always_ff @(posedge iclk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and frame outputs, decoded from state.
  always_comb begin
    state_nx  = state;
    o_len_rd  = 1'b0;
    o_len_err = 1'b0;
    o_tx_en   = 1'b0;
    o_txd     = '0;
    unique case (state)
      IDLE: begin
        if (i_len_valid && i_tx_enable) state_nx = POP;
      end
      POP: begin
        o_len_rd = 1'b1;
        state_nx = legal ? PREAMBLE : SKIP;
      end
      PREAMBLE: begin
        o_tx_en = 1'b1;
        o_txd   = pDATA_WIDTH'(8'h55);
        if (cnt == LW'(6)) state_nx = SFD;
      end
      SFD: begin
        o_tx_en  = 1'b1;
        o_txd    = pDATA_WIDTH'(8'hD5);
        state_nx = DATA;
      end
      DATA: begin
        o_tx_en = 1'b1;
        o_txd   = i_rd_data;
        if (last_data) state_nx = IFG;
      end
      SKIP: begin
        o_len_err = 1'b1;
        state_nx  = IDLE;
      end
      IFG: begin
        if (cnt == LW'(pIFG - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: length latch, phase counter, read pointer, frame count.
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      ptr     <= '0;
      len_q   <= '0;
      cnt     <= '0;
      pkt_cnt <= '0;
    end else begin
      if (state_nx != state || state == IDLE) cnt <= '0;
      else                                    cnt <= cnt + LW'(1);
      if (state == POP)  len_q <= i_len;
      if (ptr_step)      ptr   <= ptr_inc;
      if (state == SKIP) ptr   <= ptr_skip;
      if (last_data)     pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign o_rd_addr = ptr;
  assign o_pkt_cnt = pkt_cnt;

endmodule

// File: tb/tb_packet_tx_reader.sv
// Directed bench for packet_tx_reader.
// Models the length FIFO and a registered-read packet buffer.
module tb_packet_tx_reader;

  logic        iclk = 1'b0;
  logic        i_rst, i_tx_enable, i_len_valid;
  logic [11:0] i_len;
  logic        o_len_rd;
  logic [11:0] o_rd_addr;
  logic [7:0]  i_rd_data, o_txd;
  logic        o_tx_en, o_len_err;
  logic [15:0] o_pkt_cnt;

  logic [7:0]  mem [3072];
  logic [11:0] fifo [16];
  logic [3:0]  wr_idx = '0;
  logic [3:0]  rd_idx = '0;

  int         cyc = 0;
  int         errs = 0;
  logic       prev_en = 1'b0;
  int         pops[$], starts[$], ends[$];
  logic [7:0] cap[$];
  int         nchk = 0;
  int         nerr = 0;

  packet_tx_reader dut (
    .iclk        (iclk),
    .i_rst       (i_rst),
    .i_tx_enable (i_tx_enable),
    .i_len_valid (i_len_valid),
    .i_len       (i_len),
    .o_len_rd    (o_len_rd),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_tx_en     (o_tx_en),
    .o_txd       (o_txd),
    .o_len_err   (o_len_err),
    .o_pkt_cnt   (o_pkt_cnt)
  );

  always #5 iclk = ~iclk;

  assign i_len_valid = (wr_idx != rd_idx);
  assign i_len       = fifo[rd_idx];

  always @(posedge iclk) begin
    cyc <= cyc + 1;
    if (o_len_rd) rd_idx <= rd_idx + 4'd1;
    i_rd_data <= mem[o_rd_addr];
  end

  always @(negedge iclk) begin
    if (o_len_rd) pops.push_back(cyc);
    if (o_len_err) errs++;
    if (o_tx_en) begin
      cap.push_back(o_txd);
      if (!prev_en) starts.push_back(cyc);
    end else if (prev_en) begin
      ends.push_back(cyc - 1);
    end
    prev_en = o_tx_en;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iclk);
    #1;
  endtask

  task automatic push(input int l);
    fifo[wr_idx] = 12'(l);
    wr_idx = wr_idx + 4'd1;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic int capat(input int i);
    return (i < cap.size()) ? int'(cap[i]) : -1;
  endfunction

  task automatic chk_frame(input string tag, input int b,
                           input int len, input int start);
    for (int k = 0; k < 7; k++)
      chk($sformatf("%s pre%0d", tag, k), capat(b + k), 'h55);
    chk($sformatf("%s sfd", tag), capat(b + 7), 'hD5);
    for (int k = 0; k < len; k++)
      chk($sformatf("%s byte%0d", tag, k), capat(b + 8 + k),
          int'(mem[(start + k) % 3072]));
  endtask

  int b, p, s, e, rc, n;
  int ill_len [3] = '{0, 1600, 4000};
  int ill_ptr [3] = '{192, 1792, 2720};

  initial begin
    for (int i = 0; i < 3072; i++) mem[i] = 8'(i * 37 + 11);
    i_rst = 1'b1;
    i_tx_enable = 1'b0;
    tick(3);
    chk("rst tx_en", int'(o_tx_en), 0);
    chk("rst txd", int'(o_txd), 0);
    chk("rst len_rd", int'(o_len_rd), 0);
    chk("rst len_err", int'(o_len_err), 0);
    chk("rst pkt", int'(o_pkt_cnt), 0);
    chk("rst addr", int'(o_rd_addr), 0);
    i_rst = 1'b0;
    tick(2);

    // gate held low, then single 64-byte frame from address 0
    b = cap.size(); p = pops.size(); s = starts.size();
    push(64);
    tick(5);
    chk("gate nopop", pops.size() - p, 0);
    chk("gate notx", cap.size() - b, 0);
    i_tx_enable = 1'b1;
    rc = cyc;
    tick(1);
    chk("gate pop", pops.size() - p, 1);
    chk("gate lat", qat(pops, p) - rc, 1);
    tick(100);
    chk("f1 pops", pops.size() - p, 1);
    chk("f1 size", cap.size() - b, 72);
    chk_frame("f1", b, 64, 0);
    chk("f1 first", qat(starts, s) - qat(pops, p), 1);
    chk("f1 run", qat(ends, s) - qat(starts, s) + 1, 72);
    chk("f1 pkt", int'(o_pkt_cnt), 1);
    chk("f1 addr", int'(o_rd_addr), 64);

    // back-to-back frames
    b = cap.size(); p = pops.size(); s = starts.size();
    e = ends.size();
    push(64);
    push(64);
    tick(200);
    chk("b2b pops", pops.size() - p, 2);
    chk("b2b spacing", qat(pops, p + 1) - qat(pops, p), 86);
    chk("b2b gap", qat(starts, s + 1) - qat(ends, e) - 1, 14);
    chk("b2b size", cap.size() - b, 144);
    chk_frame("b2b1", b, 64, 64);
    chk_frame("b2b2", b + 72, 64, 128);
    chk("b2b pkt", int'(o_pkt_cnt), 3);
    chk("b2b addr", int'(o_rd_addr), 192);

    // illegal lengths
    for (int t = 0; t < 3; t++) begin
      b = cap.size(); p = pops.size(); n = errs;
      push(ill_len[t]);
      tick(20);
      chk($sformatf("ill%0d pops", t), pops.size() - p, 1);
      chk($sformatf("ill%0d err", t), errs - n, 1);
      chk($sformatf("ill%0d notx", t), cap.size() - b, 0);
      chk($sformatf("ill%0d addr", t), int'(o_rd_addr), ill_ptr[t]);
      chk($sformatf("ill%0d pkt", t), int'(o_pkt_cnt), 3);
    end

    // reset, skip to 3070, then wrap-around frame
    i_rst = 1'b1;
    tick(2);
    chk("rst2 addr", int'(o_rd_addr), 0);
    chk("rst2 pkt", int'(o_pkt_cnt), 0);
    i_rst = 1'b0;
    push(3070);
    tick(20);
    chk("skip addr", int'(o_rd_addr), 3070);
    b = cap.size();
    push(4);
    tick(40);
    chk("wrap size", cap.size() - b, 12);
    chk_frame("wrap", b, 4, 3070);
    chk("wrap addr", int'(o_rd_addr), 2);
    chk("wrap pkt", int'(o_pkt_cnt), 1);

    // reset during DATA byte 10
    b = cap.size();
    push(64);
    n = 0;
    while (cap.size() - b < 19 && n < 300) begin
      tick(1);
      n++;
    end
    chk("mid reach", cap.size() - b, 19);
    chk("mid byte10", capat(b + 18), int'(mem[12]));
    i_rst = 1'b1;
    tick(1);
    chk("mid tx_en", int'(o_tx_en), 0);
    chk("mid txd", int'(o_txd), 0);
    chk("mid addr", int'(o_rd_addr), 0);
    chk("mid pkt", int'(o_pkt_cnt), 0);
    i_rst = 1'b0;
    b = cap.size();
    tick(30);
    chk("mid after", cap.size() - b, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
